// File: rtl/fir_sample_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_sample_pacer                                                           |
// | Small FIFO that re-emits stream samples as single-cycle strobes spaced at  |
// | least GAP clocks apart, for the RAM-based FIR input.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_sample_pacer #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int GAP   = 513
) (
  input  logic                   clk_i,
  input  logic                   srst_n_i,
  input  logic                   s_valid_i,
  input  logic [DW-1:0]          s_data_i,
  output logic                   s_ready_o,
  output logic                   sample_valid_o,
  output logic [DW-1:0]          data_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_CW = $clog2(GAP) + 1;

  localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);
  localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_GAP_LOAD = c_CW'(GAP - 1);

  localparam logic [1:0] IDLE_S = 2'd0;
  localparam logic [1:0] EMIT_S = 2'd1;
  localparam logic [1:0] GAP_S  = 2'd2;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic [c_CW-1:0] r_gap_cnt;
  logic [1:0]      r_state;
  logic            r_ready;
  logic            r_strobe;
  logic [DW-1:0]   r_data;

  logic            w_push;
  logic            w_pop;
  logic [c_LW-1:0] w_level_nxt;
  logic [c_CW-1:0] w_gap_nxt;
  logic [1:0]      w_state_nxt;

  assign w_push = s_valid_i && r_ready;
  assign w_pop  = (r_state == EMIT_S);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + c_LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - c_LVL_ONE;
    end
  end

  always_comb begin
    w_gap_nxt = r_gap_cnt;
    if (w_pop) begin
      w_gap_nxt = c_GAP_LOAD;
    end else if (r_gap_cnt != '0) begin
      w_gap_nxt = r_gap_cnt - c_CNT_ONE;
    end
  end

  // The state names the cycle in which the pop happens; deciding on next-cycle
  // level lets a word pushed now be popped next cycle and strobed the one after.
  always_comb begin
    w_state_nxt = IDLE_S;
    case (r_state)
      IDLE_S: w_state_nxt = (w_level_nxt != '0) ? EMIT_S : IDLE_S;
      EMIT_S: begin
        if (GAP > 1) begin
          w_state_nxt = GAP_S;
        end else begin
          w_state_nxt = (w_level_nxt != '0) ? EMIT_S : IDLE_S;
        end
      end
      GAP_S: begin
        if (r_gap_cnt <= c_CNT_ONE) begin
          w_state_nxt = (w_level_nxt != '0) ? EMIT_S : IDLE_S;
        end else begin
          w_state_nxt = GAP_S;
        end
      end
      default: w_state_nxt = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_gap_cnt <= '0;
      r_state   <= IDLE_S;
      r_ready   <= 1'b0;
      r_strobe  <= 1'b0;
      r_data    <= '0;
    end else begin
      r_level   <= w_level_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_state   <= w_state_nxt;
      // Ready follows the level; a pop in the full cycle does not open a slot
      // until the next cycle.
      r_ready   <= (w_level_nxt != c_LVL_FULL);
      r_strobe  <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        r_data   <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_n_i && w_push) begin
      r_mem[r_wr_ptr] <= s_data_i;
    end
  end

  assign s_ready_o      = r_ready;
  assign sample_valid_o = r_strobe;
  assign data_o         = r_data;
  assign level_o        = r_level;

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_sample_pacer                                                        |
// | Directed bench: one pacer with GAP=513 and one with GAP=1, DEPTH=8.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_sample_pacer;

  typedef struct {
    logic [15:0] data;
    int          offset;   // accept cycle relative to previous strobe
    int          exp_rel;  // expected strobe cycle relative to previous strobe
  } vec_t;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        a_valid, b_valid;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        a_sv, b_sv;
  logic [15:0] a_dout, b_dout;
  logic [3:0]  a_level, b_level;

  fir_sample_pacer #(.DW(16), .DEPTH(8), .GAP(513)) u_dut_a (
    .clk_i(clk), .srst_n_i(srst_n), .s_valid_i(a_valid), .s_data_i(a_data),
    .s_ready_o(a_ready), .sample_valid_o(a_sv), .data_o(a_dout), .level_o(a_level)
  );

  fir_sample_pacer #(.DW(16), .DEPTH(8), .GAP(1)) u_dut_b (
    .clk_i(clk), .srst_n_i(srst_n), .s_valid_i(b_valid), .s_data_i(b_data),
    .s_ready_o(b_ready), .sample_valid_o(b_sv), .data_o(b_dout), .level_o(b_level)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  bit          b_cont  = 1'b0;
  logic [15:0] a_exp[$];
  logic [15:0] b_exp[$];
  int          a_scyc[$];
  int          b_scyc[$];
  logic [15:0] a_prev, b_prev;

  function automatic void chk(bit ok, string name, longint act, longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // One clock: record accepts, advance past the edge, then check outputs.
  task automatic tick();
    bit          rst_edge;
    logic [15:0] w;
    rst_edge = !srst_n;
    if (srst_n && a_valid && a_ready) a_exp.push_back(a_data);
    if (srst_n && b_valid && b_ready) b_exp.push_back(b_data);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_edge) begin
      a_exp.delete(); b_exp.delete(); a_scyc.delete(); b_scyc.delete();
    end else if (mon_en) begin
      chk(a_ready == (a_level != 4'd8), "a_ready_vs_level", a_ready, a_level);
      chk(b_ready == (b_level != 4'd8), "b_ready_vs_level", b_ready, b_level);
      if (a_sv) begin
        if (a_scyc.size() > 0)
          chk(cyc - a_scyc[$] >= 513, "a_spacing_min", cyc - a_scyc[$], 513);
        a_scyc.push_back(cyc);
        chk(a_exp.size() != 0, "a_strobe_expected", a_exp.size(), 1);
        if (a_exp.size() != 0) begin
          w = a_exp.pop_front();
          chk(a_dout == w, "a_order", a_dout, w);
        end
      end else begin
        chk(a_dout == a_prev, "a_data_hold", a_dout, a_prev);
      end
      if (b_sv) begin
        b_scyc.push_back(cyc);
        chk(b_exp.size() != 0, "b_strobe_expected", b_exp.size(), 1);
        if (b_exp.size() != 0) begin
          w = b_exp.pop_front();
          chk(b_dout == w, "b_order", b_dout, w);
        end
      end else begin
        chk(b_dout == b_prev, "b_data_hold", b_dout, b_prev);
      end
      if (b_cont) chk(b_level <= 4'd1, "b_level_max", b_level, 1);
    end
    a_prev = a_dout;
    b_prev = b_dout;
  endtask

  task automatic wait_a(input int bound, output int s);
    int n0;
    n0 = a_scyc.size();
    s  = -1;
    for (int i = 0; i < bound && s < 0; i++) begin
      tick();
      if (a_scyc.size() > n0) s = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    srst_n = 1'b0;
    repeat (n) tick();
    srst_n = 1'b1;
  endtask

  vec_t tbl[7];
  int   acc[13];
  int   t, s, s_prev, t0;

  initial begin
    tbl[0] = '{16'h0001, 700, 702};
    tbl[1] = '{16'hA5A5, 100, 513};
    tbl[2] = '{16'h5A5A, 510, 513};
    tbl[3] = '{16'hFFFF, 511, 513};
    tbl[4] = '{16'h0000, 512, 514};
    tbl[5] = '{16'h8001, 513, 515};
    tbl[6] = '{16'h1234,   0, 513};

    // Reset held with valid input offered: nothing may be accepted.
    srst_n  = 1'b0;
    a_valid = 1'b1; a_data = 16'h1234;
    b_valid = 1'b1; b_data = 16'h1234;
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk(a_ready == 1'b0, "rst_ready", a_ready, 0);
      chk(a_sv == 1'b0, "rst_strobe", a_sv, 0);
      chk(a_dout == 16'h0, "rst_data", a_dout, 0);
      chk(a_level == 4'd0, "rst_level", a_level, 0);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    srst_n  = 1'b1;
    tick();
    chk(a_ready == 1'b1, "rel_ready", a_ready, 1);
    chk(a_level == 4'd0, "rel_level", a_level, 0);

    // Single word: strobe at t+2, data held long after.
    a_valid = 1'b1; a_data = 16'h7FFF;
    t = cyc;
    tick();
    a_valid = 1'b0;
    wait_a(20, s);
    chk(s == t + 2, "single_latency", s, t + 2);
    chk(a_dout == 16'h7FFF, "single_data", a_dout, 16'h7FFF);
    while (cyc < t + 600) tick();
    chk(a_dout == 16'h7FFF, "single_hold_600", a_dout, 16'h7FFF);
    s_prev = s;

    // Table: words offered at various points relative to the running gap.
    for (int i = 0; i < 7; i++) begin
      while (cyc < s_prev + tbl[i].offset) tick();
      a_valid = 1'b1; a_data = tbl[i].data;
      chk(a_ready == 1'b1, "tbl_ready", a_ready, 1);
      tick();
      a_valid = 1'b0;
      wait_a(800, s);
      chk(s == s_prev + tbl[i].exp_rel, "tbl_strobe_cycle", s - s_prev, tbl[i].exp_rel);
      chk(a_dout == tbl[i].data, "tbl_data", a_dout, tbl[i].data);
      s_prev = s;
    end

    // Burst of 12 into DEPTH=8: word 1 leaves at once, so 9 go in back-to-back.
    do_reset(2);
    tick();
    for (int i = 1; i <= 12; i++) begin
      a_valid = 1'b1; a_data = 16'(i);
      for (int k = 0; k < 2000 && !a_ready; k++) tick();
      acc[i] = cyc;
      tick();
    end
    a_valid = 1'b0;
    for (int k = 0; k < 8000 && a_scyc.size() < 12; k++) tick();
    chk(a_scyc.size() == 12, "burst_count", a_scyc.size(), 12);
    chk(acc[9] == acc[1] + 8, "burst_fill", acc[9] - acc[1], 8);
    if (a_scyc.size() == 12) begin
      chk(a_scyc[0] == acc[1] + 2, "burst_first_lat", a_scyc[0] - acc[1], 2);
      chk(acc[10] == a_scyc[1], "burst_reopen_10", acc[10], a_scyc[1]);
      chk(acc[11] == a_scyc[2], "burst_reopen_11", acc[11], a_scyc[2]);
      chk(acc[12] == a_scyc[3], "burst_reopen_12", acc[12], a_scyc[3]);
      for (int k = 1; k < 12; k++)
        chk(a_scyc[k] - a_scyc[k-1] == 513, "burst_spacing", a_scyc[k] - a_scyc[k-1], 513);
    end

    // Reset with 5 words queued, 200 cycles into a gap.
    do_reset(2);
    tick();
    a_valid = 1'b1; a_data = 16'hAAAA;
    tick();
    a_valid = 1'b0;
    wait_a(20, s);
    for (int i = 1; i <= 5; i++) begin
      a_valid = 1'b1; a_data = 16'h0B00 + 16'(i);
      tick();
    end
    a_valid = 1'b0;
    while (cyc < s + 200) tick();
    chk(a_level == 4'd5, "midrst_queued", a_level, 5);
    do_reset(2);
    tick();
    chk(a_level == 4'd0, "midrst_level", a_level, 0);
    a_valid = 1'b1; a_data = 16'h8000;
    t = cyc;
    tick();
    a_valid = 1'b0;
    wait_a(20, s);
    chk(s == t + 2, "midrst_latency", s - t, 2);
    chk(a_dout == 16'h8000, "midrst_data", a_dout, 16'h8000);
    repeat (700) tick();
    chk(a_scyc.size() == 1, "midrst_no_stale", a_scyc.size(), 1);

    // GAP=1: continuous input, one strobe per cycle.
    do_reset(2);
    tick();
    b_cont  = 1'b1;
    b_valid = 1'b1;
    t0 = 0;
    for (int i = 0; i < 100; i++) begin
      b_data = 16'h0100 + 16'(i);
      for (int k = 0; k < 50 && !b_ready; k++) tick();
      if (i == 0) t0 = cyc;
      tick();
    end
    b_valid = 1'b0;
    repeat (5) tick();
    b_cont = 1'b0;
    chk(b_scyc.size() == 100, "gap1_count", b_scyc.size(), 100);
    if (b_scyc.size() == 100) begin
      chk(b_scyc[0] == t0 + 2, "gap1_first", b_scyc[0] - t0, 2);
      chk(b_scyc[99] == t0 + 101, "gap1_last", b_scyc[99] - t0, 101);
    end

    // Pointer wrap with irregular input.
    do_reset(2);
    tick();
    for (int i = 0; i < 27; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      b_valid = 1'b1; b_data = 16'($urandom);
      for (int k = 0; k < 50 && !b_ready; k++) tick();
      tick();
      b_valid = 1'b0;
    end
    repeat (5) tick();
    chk(b_scyc.size() == 27, "wrap_count", b_scyc.size(), 27);
    chk(b_exp.size() == 0, "wrap_drained", b_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
